// File: rtl/lfsr_stream_cipher.sv
// lfsr_stream_cipher
// Byte-stream XOR cipher keyed by a Fibonacci-style LFSR. In encrypt mode a
// keyed preamble (PRE_CHAR ^ mask per byte) is emitted ahead of the payload.
// In decrypt mode the same preamble is consumed and checked, then the payload
// is XOR-decrypted. Both stream sides are valid/ready with backpressure.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cfg_load              latch cfg_* (only honoured while idle)
//   cfg_mode              0 = encrypt, 1 = decrypt
//   cfg_pre_len           preamble length in bytes (0 = no preamble)
//   cfg_taps, cfg_seed    LFSR feedback mask and initial state
//   in_valid/in_ready     input byte handshake, in_data/in_last payload
//   out_valid/out_ready   output byte handshake, out_data/out_last payload
//   busy                  block is mid-message
//   done                  one-cycle pulse when a message completes
//   pre_err               sticky preamble mismatch seen while decrypting
module lfsr_stream_cipher #(
    parameter int unsigned     DW       = 8,
    parameter int unsigned     LW       = 5,
    parameter int unsigned     PLW      = 8,
    parameter logic [DW-1:0]   PRE_CHAR = DW'(8'h7E)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_load,
    input  logic           cfg_mode,
    input  logic [PLW-1:0] cfg_pre_len,
    input  logic [LW-1:0]  cfg_taps,
    input  logic [LW-1:0]  cfg_seed,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic           out_last,
    output logic           busy,
    output logic           done,
    output logic           pre_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_PRE_CHK, S_DATA, S_DRAIN, S_DONE
    } state_t;

    state_t         state;
    logic [LW-1:0]  taps_q;
    logic [LW-1:0]  lfsr;
    logic [PLW-1:0] cnt;

    logic [LW-1:0]  lfsr_next;
    logic [DW-1:0]  mask;
    logic           slot_free;
    logic           in_fire;
    logic           out_fire;

    assign lfsr_next = {lfsr[LW-2:0], ^(lfsr & taps_q)};
    assign mask      = DW'(lfsr);
    // The output register can take a new byte if it is empty or being drained
    // this very cycle, which is what gives 1 byte/cycle throughput.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = ((state == S_PRE_CHK) || (state == S_DATA)) && slot_free;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            taps_q    <= '0;
            lfsr      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            pre_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            // Default: a byte leaving the output register frees it; any load
            // below in the same cycle overrides this.
            if (out_fire)
                out_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cfg_load) begin
                        taps_q  <= cfg_taps;
                        // An all-zero state never leaves zero, so substitute all-ones.
                        lfsr    <= (cfg_seed == '0) ? '1 : cfg_seed;
                        cnt     <= cfg_pre_len;
                        pre_err <= 1'b0;
                        if (cfg_pre_len == '0)
                            state <= S_DATA;
                        else if (!cfg_mode)
                            state <= S_PRE;
                        else
                            state <= S_PRE_CHK;
                    end
                end

                S_PRE: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= PRE_CHAR ^ mask;
                        out_last  <= 1'b0;
                        lfsr      <= lfsr_next;
                        cnt       <= cnt - 1'b1;
                        if (cnt == PLW'(1))
                            state <= S_DATA;
                    end
                end

                S_PRE_CHK: begin
                    if (in_fire) begin
                        lfsr <= lfsr_next;
                        if (in_last) begin
                            // Message ended inside the preamble: flag and abandon.
                            pre_err <= 1'b1;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            if ((in_data ^ mask) != PRE_CHAR)
                                pre_err <= 1'b1;
                            cnt <= cnt - 1'b1;
                            if (cnt == PLW'(1))
                                state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (in_fire) begin
                        out_valid <= 1'b1;
                        out_data  <= in_data ^ mask;
                        out_last  <= in_last;
                        lfsr      <= lfsr_next;
                        if (in_last)
                            state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (out_fire && out_last) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lfsr_stream_cipher.md
Name: lfsr_stream_cipher

Overview:
Parametrised successor to the lab4 LFSR encryptor. Configuration arrives on ports rather than from a ROM. Operating modes:
- Encrypt: prepends a keyed preamble, then XOR-encrypts a byte stream.
- Decrypt: consumes and checks that preamble, then XOR-decrypts.
Sits between a byte source and sink; both sides use valid/ready handshakes with backpressure.

Parameters:
DW, 8, data width in bits
LW, 5, LFSR width in bits (2..DW)
PLW, 8, preamble-length counter width
PRE_CHAR, 8'h7E, preamble symbol (DW bits)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_load  in  1  latch config; honoured only in IDLE
cfg_mode  in  1  0=encrypt, 1=decrypt
cfg_pre_len  in  PLW  preamble length in bytes
cfg_taps  in  LW  feedback tap mask
cfg_seed  in  LW  initial LFSR state
in_valid  in  1  input byte valid
in_ready  out  1  block accepts input this cycle
in_data  in  DW  input byte
in_last  in  1  marks final input byte of message
out_valid  out  1  output byte valid
out_ready  in  1  sink accepts output
out_data  out  DW  output byte
out_last  out  1  marks final output byte
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at message completion
pre_err  out  1  sticky decrypt preamble mismatch; cleared by next cfg_load

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; LFSR=0; counters 0.
- LFSR step: next = {s[LW-2:0], ^(s & taps)}.
- Mask: mask = {(DW-LW)'b0, s}.
- Zero seed: cfg_seed==0 loads all-ones instead, avoiding lock-up.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = (state is PRE_CHK or DATA) & (!out_valid | out_ready).
- Output register:
  - out_data/out_last are registered, one-cycle latency from input transfer.
  - While out_valid & !out_ready, out_data and out_last hold stable.
- LFSR advances exactly once per:
  - generated preamble byte (encrypt);
  - accepted input byte (decrypt preamble and DATA).
- States:
  - IDLE: on cfg_load latch mode/pre_len/taps/seed; clear pre_err. Next state:
    - pre_len==0 -> DATA;
    - else encrypt -> PRE;
    - else decrypt -> PRE_CHK.
  - PRE (encrypt): while output slot free, emit PRE_CHAR ^ mask with out_last=0; count down. After the last preamble byte is loaded -> DATA. in_ready=0.
  - PRE_CHK (decrypt): per accepted byte, compare in_data ^ mask with PRE_CHAR.
    - Mismatch sets pre_err.
    - No output is produced.
    - After pre_len bytes -> DATA.
    - in_last during PRE_CHK: set pre_err, go to DONE immediately, no output.
  - DATA: each accepted byte -> out_data = in_data ^ mask, out_last = in_last. Once the in_last byte is accepted, in_ready drops and the FSM enters DRAIN.
  - DRAIN: wait for the output transfer of the out_last byte -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Simultaneous output transfer and new input accept in the same cycle: permitted, giving full throughput of 1 byte/cycle.
- cfg_load outside IDLE: ignored.
- pre_len counter: full PLW range. Maximum 2^PLW-1.
- Reset mid-message: async clear to IDLE. Output is dropped; no done pulse.

Test Plan:
Encryption parameters for tests 1–3: DW=8, LW=5, taps=5'h14, seed=5'h01. The LFSR sequence is 01, 02, 04, 09, 12.

1. Encrypt basic: pre_len=2, inputs 41, 42(last), out_ready=1 -> outputs 7F, 7C, 45, 4B; out_last only on 4B; done pulses once after the 4B transfer; pre_err=0.
2. Decrypt basic: same config with mode=1; inputs 7F, 7C, 45, 4B(last) -> outputs 41, 42(last); pre_err=0; done pulses once.
3. Decrypt corrupt preamble: inputs 7F, 7D, 45, 4B -> pre_err=1 from the cycle after 7D is accepted; outputs still 41, 42; pre_err holds through IDLE until the next cfg_load.
4. Backpressure: test 1 with out_ready low for 3 cycles while 7C is presented -> 7C held stable, in_ready=0, no byte lost or duplicated; final stream identical to test 1.
5. Edge configs:
   - seed=0 -> behaves as seed=5'h1F, first preamble byte = 7E^1F = 61.
   - pre_len=0 -> first output is input ^ seed mask.
   - cfg_load while busy -> ignored.
6. Reset mid-stream: assert rst after the second output byte -> all outputs 0 asynchronously; FSM in IDLE; no done pulse; a fresh config then reproduces test 1 exactly.
